// File: rtl/sdram_host_adapter_pkg.sv
// Shared definitions for the SDRAM host adapter: FSM state encoding and
// halfword select constants.
package sdram_host_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2,
        RWAIT = 2'd3
    } state_e;

    localparam logic LO_HALF = 1'b0;
    localparam logic HI_HALF = 1'b1;

endpackage

// File: rtl/sdram_host_adapter_rd_assembler.sv
// Read beat counter: captures the low and high read beats of one host read and
// emits a single-cycle 32-bit response strobe.
module sdram_rd_assembler #(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              beat_en_i,
    input  logic              bus_rvalid_i,
    input  logic [DW-1:0]     bus_rdata_i,
    output logic              done_o,
    output logic              host_rvalid_o,
    output logic [2*DW-1:0]   host_rdata_o
);

    logic [1:0]          cnt_q;
    logic [DW-1:0]       lo_q;
    logic                rvalid_q;
    logic [2*DW-1:0]     rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            lo_q     <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            if (clear_i) begin
                cnt_q <= '0;
            end else if (beat_en_i && bus_rvalid_i) begin
                // beats beyond the second are dropped
                if (cnt_q == 2'd0) begin
                    lo_q  <= bus_rdata_i;
                    cnt_q <= 2'd1;
                end else if (cnt_q == 2'd1) begin
                    rdata_q  <= {bus_rdata_i, lo_q};
                    rvalid_q <= 1'b1;
                    cnt_q    <= 2'd2;
                end
            end
        end
    end

    assign done_o        = (cnt_q == 2'd2);
    assign host_rvalid_o = rvalid_q;
    assign host_rdata_o  = rdata_q;

endmodule

// File: rtl/sdram_host_adapter.sv
// Splits 32-bit host accesses into low/high 16-bit controller accesses and
// reassembles read beats into one host read response.
//
// state | meaning
// IDLE  | ready for a host request
// LO    | low halfword access presented to the controller
// HI    | high halfword access presented to the controller
// RWAIT | read accesses issued, waiting for the second read beat
module sdram_host_adapter
    import sdram_host_adapter_pkg::*;
#(
    parameter  int DW  = 16,
    parameter  int AW  = 23,
    localparam int HDW = 2 * DW,
    localparam int HAW = AW - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_read,
    input  logic               host_write,
    input  logic [HAW-1:0]     host_addr,
    input  logic [HDW-1:0]     host_wdata,
    input  logic [HDW/8-1:0]   host_byteenable,
    output logic               host_ready,
    output logic               host_rvalid,
    output logic [HDW-1:0]     host_rdata,
    output logic               bus_read,
    output logic               bus_write,
    output logic [AW-1:0]      bus_addr,
    output logic               bus_burst,
    output logic [2:0]         bus_burst_len,
    output logic [DW-1:0]      bus_wdata,
    output logic [DW/8-1:0]    bus_byteenable,
    input  logic               bus_ready,
    input  logic               bus_rvalid,
    input  logic [DW-1:0]      bus_rdata
);

    state_e             state_q;
    logic               op_wr_q;
    logic [HAW-1:0]     addr_q;
    logic [DW-1:0]      hi_wdata_q;
    logic [DW/8-1:0]    hi_be_q;
    logic               bus_read_q;
    logic               bus_write_q;
    logic [AW-1:0]      bus_addr_q;
    logic [DW-1:0]      bus_wdata_q;
    logic [DW/8-1:0]    bus_be_q;
    logic               accept;
    logic               rd_done;

    assign host_ready = (state_q == IDLE);
    assign accept     = host_ready & (host_read | host_write);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_wr_q     <= 1'b0;
            addr_q      <= '0;
            hi_wdata_q  <= '0;
            hi_be_q     <= '0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_wr_q    <= host_write;
                        addr_q     <= host_addr;
                        hi_wdata_q <= host_wdata[HDW-1:DW];
                        hi_be_q    <= host_byteenable[HDW/8-1:DW/8];
                        // write wins when read and write arrive together
                        if (!host_write || host_byteenable[DW/8-1:0] != '0) begin
                            state_q     <= LO;
                            bus_read_q  <= ~host_write;
                            bus_write_q <= host_write;
                            bus_addr_q  <= {host_addr, LO_HALF};
                            bus_wdata_q <= host_wdata[DW-1:0];
                            bus_be_q    <= host_byteenable[DW/8-1:0];
                        end else if (host_byteenable[HDW/8-1:DW/8] != '0) begin
                            state_q     <= HI;
                            bus_write_q <= 1'b1;
                            bus_addr_q  <= {host_addr, HI_HALF};
                            bus_wdata_q <= host_wdata[HDW-1:DW];
                            bus_be_q    <= host_byteenable[HDW/8-1:DW/8];
                        end
                    end
                end
                LO: begin
                    if (bus_ready) begin
                        if (!op_wr_q || hi_be_q != '0) begin
                            state_q     <= HI;
                            bus_addr_q  <= {addr_q, HI_HALF};
                            bus_wdata_q <= hi_wdata_q;
                            bus_be_q    <= hi_be_q;
                        end else begin
                            state_q     <= IDLE;
                            bus_read_q  <= 1'b0;
                            bus_write_q <= 1'b0;
                        end
                    end
                end
                HI: begin
                    if (bus_ready) begin
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        state_q     <= op_wr_q ? IDLE : RWAIT;
                    end
                end
                RWAIT: begin
                    if (rd_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sdram_rd_assembler #(.DW(DW)) u_rd_asm (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (accept),
        .beat_en_i     ((state_q != IDLE) && !op_wr_q),
        .bus_rvalid_i  (bus_rvalid),
        .bus_rdata_i   (bus_rdata),
        .done_o        (rd_done),
        .host_rvalid_o (host_rvalid),
        .host_rdata_o  (host_rdata)
    );

    assign bus_read       = bus_read_q;
    assign bus_write      = bus_write_q;
    assign bus_addr       = bus_addr_q;
    assign bus_wdata      = bus_wdata_q;
    assign bus_byteenable = bus_be_q;
    assign bus_burst      = 1'b0;
    assign bus_burst_len  = 3'd0;

endmodule

// File: tb/tb_sdram_host_adapter.sv
// Scoreboard bench for sdram_host_adapter: a host driver, a controller model
// with memory and random stalls, and a host response monitor.
module tb_sdram_host_adapter;

    localparam int DW  = 16;
    localparam int AW  = 23;
    localparam int HDW = 32;
    localparam int HAW = 22;

    logic              clk = 1'b0;
    logic              rst;
    logic              host_read, host_write;
    logic [HAW-1:0]    host_addr;
    logic [HDW-1:0]    host_wdata;
    logic [3:0]        host_byteenable;
    logic              host_ready, host_rvalid;
    logic [HDW-1:0]    host_rdata;
    logic              bus_read, bus_write, bus_burst;
    logic [AW-1:0]     bus_addr;
    logic [2:0]        bus_burst_len;
    logic [DW-1:0]     bus_wdata, bus_rdata;
    logic [1:0]        bus_byteenable;
    logic              bus_ready, bus_rvalid;

    always #5 clk = ~clk;

    sdram_host_adapter dut (
        .clk(clk), .rst(rst),
        .host_read(host_read), .host_write(host_write), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_byteenable(host_byteenable),
        .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_burst(bus_burst), .bus_burst_len(bus_burst_len),
        .bus_wdata(bus_wdata), .bus_byteenable(bus_byteenable),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] wd; logic [1:0] be; } acc_t;
    typedef struct { logic [AW-1:0] addr; int dly; } beat_t;

    acc_t        exp_acc[$];
    logic [31:0] exp_rd[$];
    beat_t       bq[$];
    logic [15:0] ctl_mem [logic [AW-1:0]];
    logic [31:0] ref_mem [logic [HAW-1:0]];

    int n_chk = 0;
    int n_fail = 0;
    int ready_mode = 0;
    int beat_dly = -1;
    bit manual = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got an unexpected condition, required none", name);
    endtask

    function automatic logic [15:0] hdef(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'hA5, a[7:0] + 8'h3C};
    endfunction

    function automatic logic [15:0] ctl_rd(input logic [AW-1:0] a);
        return ctl_mem.exists(a) ? ctl_mem[a] : hdef(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [HAW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : {hdef({a, 1'b1}), hdef({a, 1'b0})};
    endfunction

    // Host-level reference: which halfword accesses a request must cause and
    // what a read must return, from a 32-bit word memory.
    function automatic void model(input bit rd, input bit wr, input logic [HAW-1:0] a,
                                  input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] w;
        if (wr) begin
            w = ref_rd(a);
            for (int h = 0; h < 2; h++)
                if (be[2*h +: 2] != 2'b00)
                    exp_acc.push_back('{1'b1, {a, h[0]}, wd[16*h +: 16], be[2*h +: 2]});
            for (int b = 0; b < 4; b++)
                if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_mem[a] = w;
        end else if (rd) begin
            exp_acc.push_back('{1'b0, {a, 1'b0}, 16'h0, 2'b00});
            exp_acc.push_back('{1'b0, {a, 1'b1}, 16'h0, 2'b00});
            exp_rd.push_back(ref_rd(a));
        end
    endfunction

    // Controller model: stalls, memory updates, read beats, and access checks.
    initial begin
        logic [AW-1:0] p_addr;
        logic [15:0]   p_wd, cur;
        logic [1:0]    p_be;
        bit            p_rd, p_wr, stalled, req;
        int            stall_cnt;
        acc_t          e;
        stalled = 1'b0; stall_cnt = 0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (manual || rst) begin
                stalled = 1'b0; stall_cnt = 0;
                continue;
            end
            bus_rvalid = 1'b0;
            if (bq.size() > 0) begin
                if (bq[0].dly <= 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = ctl_rd(bq[0].addr);
                    void'(bq.pop_front());
                end else begin
                    bq[0].dly = bq[0].dly - 1;
                end
            end
            if (stalled)
                check("stall_hold", {bus_read, bus_write, bus_addr, bus_wdata, bus_byteenable},
                      {p_rd, p_wr, p_addr, p_wd, p_be});
            req = bus_read | bus_write;
            case (ready_mode)
                1:       bus_ready = 1'b1;
                2:       bus_ready = (stall_cnt >= 3);
                3:       bus_ready = bus_addr[0] ? (stall_cnt >= 4) : 1'b1;
                default: bus_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (req && bus_ready) begin
                if (exp_acc.size() == 0) begin
                    fail("unexpected_bus_access");
                end else begin
                    e = exp_acc.pop_front();
                    check("bus_op", {bus_write, bus_read}, {e.wr, ~e.wr});
                    check("bus_addr", bus_addr, e.addr);
                    if (e.wr) begin
                        check("bus_wdata", bus_wdata, e.wd);
                        check("bus_be", bus_byteenable, e.be);
                    end
                end
                if (bus_write) begin
                    cur = ctl_rd(bus_addr);
                    if (bus_byteenable[0]) cur[7:0]  = bus_wdata[7:0];
                    if (bus_byteenable[1]) cur[15:8] = bus_wdata[15:8];
                    ctl_mem[bus_addr] = cur;
                end
                if (bus_read)
                    bq.push_back('{bus_addr, (beat_dly < 0) ? int'($urandom_range(0, 3)) : beat_dly});
                stalled = 1'b0; stall_cnt = 0;
            end else if (req) begin
                stalled = 1'b1; stall_cnt++;
                p_rd = bus_read; p_wr = bus_write; p_addr = bus_addr;
                p_wd = bus_wdata; p_be = bus_byteenable;
            end else begin
                stalled = 1'b0; stall_cnt = 0;
            end
        end
    end

    // Host response monitor.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (host_rvalid) begin
                if (exp_rd.size() == 0) begin
                    fail("unexpected_host_rvalid");
                end else begin
                    exp = exp_rd.pop_front();
                    check("host_rdata", host_rdata, exp);
                end
            end
        end
    end

    task automatic do_op(input bit rd, input bit wr, input logic [HAW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        int t;
        t = 0;
        @(negedge clk);
        while (!host_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) fail("host_ready_timeout");
        host_read = rd; host_write = wr; host_addr = a;
        host_wdata = wd; host_byteenable = be;
        model(rd, wr, a, wd, be);
        @(negedge clk);
        host_read = 1'b0; host_write = 1'b0;
    endtask

    task automatic wait_quiet();
        int t;
        t = 0;
        while ((exp_acc.size() != 0 || exp_rd.size() != 0 || bq.size() != 0 || !host_ready) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) fail("quiet_timeout");
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, host_ready, 1'b1);
        check({tag, "_rvalid"}, host_rvalid, 1'b0);
        check({tag, "_rdata"}, host_rdata, 32'h0);
        check({tag, "_bus_req"}, {bus_read, bus_write}, 2'b00);
        check({tag, "_bus_addr"}, bus_addr, 23'h0);
        check({tag, "_bus_wdata_be"}, {bus_wdata, bus_byteenable}, 18'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        host_read = 1'b0; host_write = 1'b0; host_addr = '0;
        host_wdata = '0; host_byteenable = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // full write, controller always ready
        ready_mode = 1;
        do_op(1'b0, 1'b1, 22'h10, 32'hDEADBEEF, 4'hF);
        check("w1_lo_access", {host_ready, bus_write, bus_addr, bus_wdata}, {1'b0, 1'b1, 23'h20, 16'hBEEF});
        @(negedge clk);
        check("w1_hi_access", {host_ready, bus_write, bus_addr, bus_wdata}, {1'b0, 1'b1, 23'h21, 16'hDEAD});
        @(negedge clk);
        check("w1_ready_back", host_ready, 1'b1);
        wait_quiet();

        // high-only write, then a write with no byte enables
        do_op(1'b0, 1'b1, 22'h5, 32'hDEADBEEF, 4'b1100);
        wait_quiet();
        do_op(1'b0, 1'b1, 22'h5, 32'h01234567, 4'b0000);
        check("w0_ready", {host_ready, bus_write}, 2'b10);
        @(negedge clk);
        check("w0_no_access", {host_ready, bus_write}, 2'b10);
        wait_quiet();

        // read with 3-cycle stalls, beats returned in RWAIT
        ready_mode = 2; beat_dly = 5;
        ctl_mem[23'h6] = 16'h1234; ctl_mem[23'h7] = 16'h5678;
        ref_mem[22'h3] = 32'h56781234;
        do_op(1'b1, 1'b0, 22'h3, 32'h0, 4'h0);
        wait_quiet();

        // low beat arrives while the high access is still stalled
        ready_mode = 3; beat_dly = 0;
        do_op(1'b1, 1'b0, 22'h7, 32'h0, 4'h0);
        wait_quiet();

        // read and write together act as a write
        ready_mode = 0; beat_dly = -1;
        do_op(1'b1, 1'b1, 22'h7, 32'hCAFEF00D, 4'b0110);
        wait_quiet();
        do_op(1'b1, 1'b0, 22'h7, 32'h0, 4'h0);
        wait_quiet();

        // reset in HI with one beat captured
        manual = 1'b1;
        bus_ready = 1'b1; bus_rvalid = 1'b0;
        @(negedge clk);
        host_read = 1'b1; host_addr = 22'h9;
        @(negedge clk);
        host_read = 1'b0;
        check("rst_lo_addr", {bus_read, bus_addr}, {1'b1, 23'h12});
        @(negedge clk);
        check("rst_hi_addr", {host_ready, bus_read, bus_addr}, {1'b0, 1'b1, 23'h13});
        bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 16'hAAAA;
        @(negedge clk);
        bus_rvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrst");
        manual = 1'b0;
        do_op(1'b1, 1'b0, 22'h9, 32'h0, 4'h0);
        wait_quiet();

        // random traffic
        for (int i = 0; i < 150; i++) begin
            logic [2:0] k;
            k = 3'($urandom_range(0, 7));
            ready_mode = 0;
            beat_dly = -1;
            do_op(k < 3'd3, k >= 3'd3 && k != 3'd7 ? 1'b1 : (k == 3'd7),
                  22'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) wait_quiet();
        end
        wait_quiet();

        check("burst_tied", {bus_burst, bus_burst_len}, 4'h0);
        check("acc_queue_empty", exp_acc.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_host_adapter.md
Name: sdram_host_adapter

Overview:
- Upstream stage of the SDRAM controller. Converts a 32-bit host request bus into the controller's 16-bit single-access bus (read/write/addr/wdata/byteenable, ready, rvalid/rdata).
- Splits each host word into a low and a high halfword access.
- Skips halfword writes that have no enabled bytes.
- Reassembles the two read beats into one 32-bit read response.
- Handles one host transaction at a time.

Parameters:
DW, 16, SDRAM/controller data width (bits)
AW, 23, controller halfword address width
HDW, 2*DW, host data width (derived, do not override)
HAW, AW-1, host word address width (derived)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
host_read  in  1  host read request
host_write  in  1  host write request
host_addr  in  HAW  host word address
host_wdata  in  HDW  host write data
host_byteenable  in  HDW/8  host byte enables
host_ready  out  1  request accepted this cycle when asserted with read or write
host_rvalid  out  1  one-cycle read response strobe
host_rdata  out  HDW  read data, valid with host_rvalid
bus_read  out  1  controller read request
bus_write  out  1  controller write request
bus_addr  out  AW  controller halfword address
bus_burst  out  1  tied 0
bus_burst_len  out  3  tied 0
bus_wdata  out  DW  controller write data
bus_byteenable  out  DW/8  controller byte enables
bus_ready  in  1  controller accepts the current request
bus_rvalid  in  1  controller read beat valid
bus_rdata  in  DW  controller read beat data

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset values: state IDLE; host_rvalid, bus_read, bus_write = 0; host_rdata, bus_addr, bus_wdata, bus_byteenable, beat count, captured data = 0.
- host_ready = (state == IDLE), combinational from state only. Acceptance = host_ready & (host_read | host_write).
- If host_read and host_write are asserted together, the request is treated as a write.
- On accept, latch addr, wdata, byteenable and op.
- Halfword mapping (little-endian):
  - low half = address {host_addr,1'b0}, data [DW-1:0], be [1:0]
  - high half = address {host_addr,1'b1}, data [HDW-1:DW], be [3:2]
- States: IDLE, LO, HI, RWAIT.
- IDLE -> LO on accept, when the op is a read or be[1:0] != 0.
- IDLE -> HI on accept of a write with be[1:0] == 0 and be[3:2] != 0.
- IDLE -> IDLE on accept of a write with all byteenables 0. No controller access occurs; the transaction completes immediately.
- LO and HI drive registered bus_read or bus_write, with addr/wdata/be valid from the first cycle in the state. These signals are held stable until bus_ready = 1.
- LO on bus_ready: go to HI if (read or be[3:2] != 0), else go to IDLE. Request signals drop the next cycle unless HI is entered, in which case they update to the high half with no idle gap.
- HI on bus_ready: read goes to RWAIT; write goes to IDLE.
- Read beats are counted from accept onward, in any state. bus_rvalid may arrive while still in LO or HI.
  - Beat 0 is captured as the low half, beat 1 as the high half.
  - In RWAIT, if beat 1 has already been captured, return to IDLE next cycle.
- bus_rvalid received in IDLE, or a third beat, is ignored.
- host_rvalid pulses for exactly one cycle, the cycle after the second beat is captured. host_rdata = {hi,lo} is registered at that time and holds until the next response.
- Write completion has no response strobe.
- Reset mid-transaction returns to IDLE and discards captured beats. The controller must be reset in the same cycle.

Decomposition:
- Shared sdram package holds:
  - state enum typedef (IDLE/LO/HI/RWAIT)
  - halfword select constants (LO_HALF=0, HI_HALF=1)
- Natural sub-module: sdram_rd_assembler, a beat counter plus low/high capture and rvalid pulse generation. It is cleared at accept and reset.

Test Plan:
- Write host_addr=0x10, wdata=0xDEADBEEF, be=4'hF, bus_ready=1 always. Expect two consecutive cycles: (addr 0x20, wdata 0xBEEF, be 2'b11), then (addr 0x21, wdata 0xDEAD, be 2'b11). host_ready returns 1 two cycles after accept.
- Write be=4'b1100, then write be=4'b0000. Expect the first write to produce only the high access (addr odd, wdata 0xDEAD). The second write produces no bus_write, and host_ready stays 1.
- Read host_addr=0x3; the controller holds bus_ready=0 for 3 cycles per access, then returns beats 0x1234 and 0x5678 in RWAIT. Expect addr 0x6 then 0x7, each held stable while stalled. Expect a host_rvalid single pulse with rdata=0x56781234.
- Read where the low beat's bus_rvalid arrives while still in HI. Expect correct ordering and rdata={hi,lo}, with no early host_rvalid.
- Assert host_read and host_write together. Expect write behaviour; host_rvalid never asserts.
- Assert rst in HI with one beat captured, then perform a new read. Expect all outputs 0 the cycle after reset, and the new read's rdata made only from its own beats.
